id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001: id_ex_stage SHALL have one clock; reset is synchronous and active-high; the clock and reset ports are named clk and reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004: Flush  input  1  synchronous discard of all held operations (branch/jump redirect).
REQ-005: InValid  input  1  upstream (decode) presents an operation.
REQ-006: InReady  output  1  stage can accept an operation this cycle.
REQ-007: InA, InB  input  32 each  decoded operand values.
REQ-008: InALUControl  input  3  ALU op code: 000 add, 001 sub, 010 and, 011 or.
REQ-009: InRd  input  5  destination register index.
REQ-010: InRegWrite  input  1  operation writes the register file.
REQ-011: OutValid  output  1  held operation presented to the ALU/execute side.
REQ-012: OutReady  input  1  downstream consumes the presented operation.
REQ-013: A, B  output  32 each  ALU operands.
REQ-014: ALUControl  output  3  ALU op code.
REQ-015: Rd  output  5  destination register index.
REQ-016: RegWrite  output  1  write enable; forced 0 whenever OutValid is 0.
REQ-017: StallCount  output  16  saturating count of downstream back-pressure cycles.

Function
REQ-018: The stage SHALL be a two-entry skid buffer (main entry, skid entry) with states EMPTY, ONE, FULL.
REQ-019: Accept = InValid & InReady; Consume = OutValid & OutReady; both evaluated on the same rising edge.
REQ-020: InReady SHALL be a registered output, 1 in EMPTY and ONE, 0 in FULL; it never depends combinationally on OutReady.
REQ-021: OutValid SHALL be 1 in ONE and FULL and 0 in EMPTY; A, B, ALUControl, Rd, RegWrite always come from the main entry.
REQ-022: EMPTY: Accept -> main <= inputs, go ONE; otherwise stay EMPTY.
REQ-023: ONE: Accept & Consume -> main <= inputs, stay ONE; Accept only -> skid <= inputs, go FULL; Consume only -> go EMPTY; neither -> hold.
REQ-024: FULL: Consume -> main <= skid, go ONE; otherwise hold both entries unchanged.
REQ-025: Latency SHALL be exactly one cycle from Accept to OutValid=1 with the accepted data, when the stage was EMPTY or consuming.
REQ-026: Order SHALL be preserved; no operation is duplicated or dropped except by Flush or reset.
REQ-027: Flush SHALL take priority over Accept and Consume: next state EMPTY, InReady=1 next cycle, any operation offered in the flush cycle is discarded.
REQ-028: A, B, ALUControl, Rd SHALL hold their last value in EMPTY; RegWrite SHALL read 0 in EMPTY.
REQ-029: StallCount SHALL increment by 1 each cycle with OutValid=1 and OutReady=0, saturate at 16'hFFFF, and be unaffected by Flush.
REQ-030: Operand widths SHALL pass unchanged; the stage performs no arithmetic on A, B.

Reset
REQ-031: On reset: state EMPTY, OutValid=0, InReady=1, A=B=0, ALUControl=000, Rd=0, RegWrite=0, StallCount=0, skid entry cleared.
REQ-032: Reset SHALL take priority over Flush, Accept and Consume, including mid-transfer in FULL.
REQ-033: The first Accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-034: Stream: OutReady=1, InValid=1 with InA=5, InB=3, InALUControl=001 for one cycle -> next cycle OutValid=1, A=5, B=3, ALUControl=001; cycle after, OutValid=0.
REQ-035: Back-pressure: OutReady=0, send ops X (InA=1) then Y (InA=2) -> FULL, InReady=0, A=1; raise OutReady -> A=1 consumed, then A=2, then EMPTY; StallCount equals held cycles.
REQ-036: Flush in FULL with InValid=1 (InA=9) -> next cycle OutValid=0, RegWrite=0, InReady=1; op 9 never appears.
REQ-037: Simultaneous Accept & Consume in ONE for 100 cycles with InA incrementing -> A tracks InA delayed one cycle, never FULL.
REQ-038: Reset asserted in FULL -> next cycle all outputs at reset values; StallCount held at FFFF after 70000 stalled cycles before reset.

Source files
------------

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : id_ex_stage_if                                     |
// | Description : Decode-to-execute handshake and operand bus.       |
// |               The master side is the decode/ALU environment and  |
// |               the slave side is the pipeline register stage.     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface id_ex_stage_if;
  // Upstream (decode) side
  logic        InValid;
  logic        InReady;
  logic [31:0] InA;
  logic [31:0] InB;
  logic [2:0]  InALUControl;
  logic [4:0]  InRd;
  logic        InRegWrite;
  // Downstream (execute) side
  logic        OutValid;
  logic        OutReady;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUControl;
  logic [4:0]  Rd;
  logic        RegWrite;

  modport master (
    output InValid, InA, InB, InALUControl, InRd, InRegWrite, OutReady,
    input  InReady, OutValid, A, B, ALUControl, Rd, RegWrite
  );

  modport slave (
    input  InValid, InA, InB, InALUControl, InRd, InRegWrite, OutReady,
    output InReady, OutValid, A, B, ALUControl, Rd, RegWrite
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : id_ex_stage                                        |
// | Description : ID/EX pipeline register built as a two-entry skid  |
// |               buffer with registered InReady, flush support and  |
// |               a saturating back-pressure cycle counter.          |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module id_ex_stage (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        Flush,
  id_ex_stage_if.slave     bus,
  output logic [15:0]      StallCount
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_next;
  logic        r_in_ready;

  // Main entry drives the ALU; skid entry catches the op accepted while stalled
  logic [31:0] r_main_a,  r_skid_a;
  logic [31:0] r_main_b,  r_skid_b;
  logic [2:0]  r_main_op, r_skid_op;
  logic [4:0]  r_main_rd, r_skid_rd;
  logic        r_main_rw, r_skid_rw;
  logic [15:0] r_stall;

  logic w_accept;
  logic w_consume;
  logic w_out_valid;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = bus.InValid & r_in_ready;
  assign w_consume   = w_out_valid & bus.OutReady;

  // Next-state and entry-load decode; Flush overrides any transfer
  always_comb begin
    w_next           = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (Flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_next         = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_next      = S_FULL;
          end else if (w_consume) begin
            w_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_consume) begin
            w_load_main_skid = 1'b1;
            w_next           = S_ONE;
          end
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // State, registered InReady and the two operation entries
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main_a   <= '0;
      r_main_b   <= '0;
      r_main_op  <= '0;
      r_main_rd  <= '0;
      r_main_rw  <= 1'b0;
      r_skid_a   <= '0;
      r_skid_b   <= '0;
      r_skid_op  <= '0;
      r_skid_rd  <= '0;
      r_skid_rw  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_FULL);
      if (w_load_main_in) begin
        r_main_a  <= bus.InA;
        r_main_b  <= bus.InB;
        r_main_op <= bus.InALUControl;
        r_main_rd <= bus.InRd;
        r_main_rw <= bus.InRegWrite;
      end else if (w_load_main_skid) begin
        r_main_a  <= r_skid_a;
        r_main_b  <= r_skid_b;
        r_main_op <= r_skid_op;
        r_main_rd <= r_skid_rd;
        r_main_rw <= r_skid_rw;
      end
      if (w_load_skid) begin
        r_skid_a  <= bus.InA;
        r_skid_b  <= bus.InB;
        r_skid_op <= bus.InALUControl;
        r_skid_rd <= bus.InRd;
        r_skid_rw <= bus.InRegWrite;
      end
    end
  end

  // Count cycles where a valid op waits on downstream; Flush does not touch it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_out_valid && !bus.OutReady && (r_stall != c_STALL_MAX)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign bus.InReady    = r_in_ready;
  assign bus.OutValid   = w_out_valid;
  assign bus.A          = r_main_a;
  assign bus.B          = r_main_b;
  assign bus.ALUControl = r_main_op;
  assign bus.Rd         = r_main_rd;
  assign bus.RegWrite   = r_main_rw & w_out_valid;
  assign StallCount     = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_id_ex_stage                                     |
// | Description : Scoreboard bench for id_ex_stage. Stimulus pushes  |
// |               accepted ops into an in-order queue; a monitor     |
// |               compares the presented op and handshake each cycle.|
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [4:0]  rd;
    logic        rw;
  } op_t;

  logic        clk;
  logic        reset;
  logic        Flush;
  logic [15:0] StallCount;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk        (clk),
    .reset      (reset),
    .Flush      (Flush),
    .bus        (bus),
    .StallCount (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ops held by the stage, in order (front = presented op)
  op_t         exp_q[$];
  bit          pend;       // an op pushed for the coming edge, not yet held
  bit          armed;      // a reset has been seen
  op_t         last_main;  // value the operand outputs must hold when empty
  int unsigned m_stall;
  int          passed;
  int          total;
  int          held;
  op_t         front;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare at each rising edge with the pre-edge outputs, then advance model
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend      = 1'b0;
      armed     = 1'b1;
      last_main = '0;
      m_stall   = 0;
    end else if (armed) begin
      held = exp_q.size() - int'(pend);
      chk("OutValid", 64'(bus.OutValid), 64'(held > 0));
      chk("InReady", 64'(bus.InReady), 64'(held < 2));
      chk("StallCount", 64'(StallCount), 64'(m_stall));
      if (held > 0) begin
        front = exp_q[0];
        last_main = front;
        chk("A", 64'(bus.A), 64'(front.a));
        chk("B", 64'(bus.B), 64'(front.b));
        chk("ALUControl", 64'(bus.ALUControl), 64'(front.c));
        chk("Rd", 64'(bus.Rd), 64'(front.rd));
        chk("RegWrite", 64'(bus.RegWrite), 64'(front.rw));
        if (!bus.OutReady && m_stall < 32'hFFFF) m_stall++;
      end else begin
        chk("RegWrite_empty", 64'(bus.RegWrite), 64'd0);
        chk("A_hold", 64'(bus.A), 64'(last_main.a));
        chk("B_hold", 64'(bus.B), 64'(last_main.b));
        chk("Rd_hold", 64'(bus.Rd), 64'(last_main.rd));
      end
      if (Flush) begin
        exp_q.delete();
      end else if (held > 0 && bus.OutReady) begin
        void'(exp_q.pop_front());
      end
      pend = 1'b0;
    end
  end

  // One cycle of stimulus, applied on the falling edge
  task automatic drive(input bit r, input bit f, input bit v, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] c, input logic [4:0] rd,
                       input bit rw, input bit ordy);
    op_t op;
    @(negedge clk);
    reset            = r;
    Flush            = f;
    bus.InValid      = v;
    bus.InA          = a;
    bus.InB          = b;
    bus.InALUControl = c;
    bus.InRd         = rd;
    bus.InRegWrite   = rw;
    bus.OutReady     = ordy;
    op = '{a: a, b: b, c: c, rd: rd, rw: rw};
    if (armed && !r && !f && v && exp_q.size() < 2) begin
      exp_q.push_back(op);
      pend = 1'b1;
    end
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'b0, $urandom, $urandom, 3'($urandom_range(0, 3)), 5'($urandom), 1'b1, ordy);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c, input bit ordy);
    drive(1'b0, 1'b0, 1'b1, a, b, c, 5'($urandom), 1'b1, ordy);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    pend   = 1'b0;
    armed  = 1'b0;
    m_stall = 0;
    last_main = '0;
    reset = 1'b1;
    Flush = 1'b0;
    bus.InValid = 1'b0;
    bus.InA = '0;
    bus.InB = '0;
    bus.InALUControl = '0;
    bus.InRd = '0;
    bus.InRegWrite = 1'b0;
    bus.OutReady = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);

    // Single op streamed straight through
    send(32'd5, 32'd3, 3'b001, 1'b1);
    idle(1'b1, 3);

    // Back-pressure fills both entries, then drains in order
    send(32'd1, 32'd11, 3'b000, 1'b0);
    send(32'd2, 32'd22, 3'b010, 1'b0);
    idle(1'b0, 4);
    idle(1'b1, 4);

    // Flush while full discards held ops and the op offered that cycle
    send(32'd7, 32'd1, 3'b011, 1'b0);
    send(32'd8, 32'd2, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'd9, 32'd9, 3'b001, 5'd9, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Continuous accept and consume keeps one op in flight
    for (int i = 0; i < 100; i++) send(32'(100 + i), 32'(i), 3'(i % 4), 1'b1);
    idle(1'b1, 2);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 7), $urandom, $urandom,
            3'($urandom_range(0, 3)), 5'($urandom), 1'($urandom),
            ($urandom_range(0, 9) < 6));
    end
    idle(1'b1, 3);

    // Long stall saturates StallCount, then reset in FULL
    send(32'hA, 32'hB, 3'b001, 1'b0);
    send(32'hC, 32'hD, 3'b010, 1'b0);
    idle(1'b0, 70000);
    drive(1'b1, 1'b0, 1'b1, 32'hE, 32'hE, 3'b011, 5'd1, 1'b1, 1'b0);
    idle(1'b0, 3);
    send(32'h55, 32'h66, 3'b000, 1'b1);
    idle(1'b1, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
